ebi_dpram_arbiter: RTL

Arbitrates two synchronized PPC external-bus channels (core A, core B) onto one single-port shared RAM used as the inter-core mailbox in the dual-core system. Each channel presents the already-synchronized level strobes and word address produced by its bus-interface front end. The block detects new accesses, queues one per core, serializes them onto the RAM with round-robin fairness and returns read data with a one-cycle done pulse.

---
 rtl/ebi_dpram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ebi_dpram_arbiter.sv
// ebi_dpram_arbiter: serializes two PPC EBI channels onto one single-port mailbox RAM
// Ports: clk, rst_n (async active-low); per core x in {a,b}: x_re/x_we level strobes,
// x_addr/x_wdata request, x_rdata last read data, x_done one-cycle completion pulse;
// RAM side: registered ram_cs/ram_we/ram_addr/ram_wdata, ram_rdata one cycle after a read;
// grant {b,a} one-hot owner of the current access.
// Build option: ARB_FIXED_PRIO_EN makes core A win every tie instead of round-robin.
module ebi_dpram_arbiter #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_re,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  input  logic          b_re,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    grant
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic a_stb_q, a_pend, a_kind, b_stb_q, b_pend, b_kind;
  logic [AW-1:0] a_addr_q, b_addr_q, ram_addr_nx;
  logic [DW-1:0] a_wdata_q, b_wdata_q, ram_wdata_nx, a_rdata_nx, b_rdata_nx;
  logic a_rise, b_rise, a_clr, b_clr, go, win_a, a_prio, ram_we_nx;
  logic [1:0] grant_nx;
  assign a_rise = (a_re | a_we) & ~a_stb_q;
  assign b_rise = (b_re | b_we) & ~b_stb_q;
  assign a_clr  = (state == RESP) & grant[0];
  assign b_clr  = (state == RESP) & grant[1];
  // A request is latched only when the queue slot is free or being freed this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {a_stb_q, a_pend, a_kind, b_stb_q, b_pend, b_kind} <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      a_wdata_q <= '0;
      b_wdata_q <= '0;
    end else begin
      a_stb_q <= a_re | a_we;
      b_stb_q <= b_re | b_we;
      a_pend  <= a_rise | (a_pend & ~a_clr);
      b_pend  <= b_rise | (b_pend & ~b_clr);
      if (a_rise & (~a_pend | a_clr)) begin
        a_kind    <= a_we;
        a_addr_q  <= a_addr;
        a_wdata_q <= a_wdata;
      end
      if (b_rise & (~b_pend | b_clr)) begin
        b_kind    <= b_we;
        b_addr_q  <= b_addr;
        b_wdata_q <= b_wdata;
      end
    end
  end
`ifdef ARB_FIXED_PRIO_EN
  assign a_prio = 1'b1;
`else
  // Remembers the winner of the last contested arbitration; uncontested grants
  // (including the back-to-back hand-over from RESP) do not move it.
  logic last_b, tie;
  assign tie    = (state == IDLE) & a_pend & b_pend;
  assign a_prio = last_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b <= 1'b1;
    else if (go & tie) last_b <= ~win_a;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // From RESP only the other core may be granted directly; the owner's fresh
  // request goes back through IDLE.
  always_comb begin
    state_nx = state == IDLE   ? ((a_pend | b_pend) ? ACCESS : IDLE) :
               state == ACCESS ? RESP :
               ((grant[0] ? b_pend : a_pend) ? ACCESS : IDLE);
    go       = state_nx == ACCESS;
    win_a    = state == IDLE ? a_pend & (~b_pend | a_prio) : grant[1];
  end
  always_comb begin
    ram_we_nx    = go & (win_a ? a_kind : b_kind);
    ram_addr_nx  = go ? (win_a ? a_addr_q : b_addr_q) : ram_addr;
    ram_wdata_nx = go ? (win_a ? a_wdata_q : b_wdata_q) : ram_wdata;
    grant_nx     = go ? {~win_a, win_a} : (state == RESP ? 2'b00 : grant);
    a_rdata_nx   = (a_clr & ~a_kind) ? ram_rdata : a_rdata;
    b_rdata_nx   = (b_clr & ~b_kind) ? ram_rdata : b_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ram_cs, ram_we, a_done, b_done} <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      grant     <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      ram_cs    <= go;
      ram_we    <= ram_we_nx;
      ram_addr  <= ram_addr_nx;
      ram_wdata <= ram_wdata_nx;
      grant     <= grant_nx;
      a_done    <= a_clr;
      b_done    <= b_clr;
      a_rdata   <= a_rdata_nx;
      b_rdata   <= b_rdata_nx;
    end
  end
endmodule
